// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD down counter (99..00): load, start/pause, TICK_DIV prescaler, one-cycle done pulse.
// Optional BCD_TIMER_AUTO_RELOAD_EN: the terminal tick reloads the preset and keeps running.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] cnt_tens,
    output logic [3:0] cnt_ones,
    output logic       running,
    output logic       done
);

    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [3:0]    ld_tens, ld_ones;
    logic          count_zero, count_one;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    logic [7:0]    reload_q, reload_d;
`endif

    always_comb begin
        ld_tens    = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
        ld_ones    = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
        count_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
        count_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif

        if (load) begin
            state_d = IDLE;
            tens_d  = ld_tens;
            ones_d  = ld_ones;
            presc_d = '0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload_d = {ld_tens, ld_ones};
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !count_zero) begin
                        state_d = RUN;
                        presc_d = '0;
                    end
                end
                RUN: begin
                    // pause beats a tick that is due on the same edge
                    if (pause) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (count_one) begin
                            done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                            tens_d = reload_q[7:4];
                            ones_d = reload_q[3:0];
`else
                            tens_d  = 4'd0;
                            ones_d  = 4'd0;
                            state_d = DONE;
`endif
                        end else if (!count_zero) begin
                            if (ones_q == 4'd0) begin
                                ones_d = 4'd9;
                                tens_d = tens_q - 4'd1;
                            end else begin
                                ones_d = ones_q - 4'd1;
                            end
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (start) state_d = RUN;
                end
                default: ;
            endcase
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload_q  <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign cnt_tens = tens_q;
    assign cnt_ones = ones_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random stimulus against a decimal reference model.
module tb_bcd_countdown_timer;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] cnt_tens, cnt_ones;
    logic       running, done;

    bcd_countdown_timer #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .cnt_tens(cnt_tens), .cnt_ones(cnt_ones),
        .running(running), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: count is a plain decimal integer, elapsed counts RUN cycles since the last tick.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_count   = 0;
    int m_state   = M_IDLE;
    int m_elapsed = 0;
    int m_reload  = 0;
    int m_done    = 0;

    task automatic model_step(input bit r, input bit l, input logic [7:0] lv, input bit s, input bit p);
        int t, o;
        m_done = 0;
        if (r) begin
            m_count = 0; m_state = M_IDLE; m_elapsed = 0; m_reload = 0;
        end else if (l) begin
            t = int'(lv[7:4]); o = int'(lv[3:0]);
            if (t > 9) t = 9;
            if (o > 9) o = 9;
            m_count = 10 * t + o; m_reload = m_count;
            m_state = M_IDLE; m_elapsed = 0;
        end else begin
            case (m_state)
                M_IDLE: if (s && m_count != 0) begin m_state = M_RUN; m_elapsed = 0; end
                M_RUN: begin
                    if (p) m_state = M_PAUSE;
                    else begin
                        m_elapsed++;
                        if (m_elapsed == TICK_DIV) begin
                            m_elapsed = 0;
                            if (m_count == 1) begin
                                m_done = 1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                                m_count = m_reload;
`else
                                m_count = 0;
                                m_state = M_DONE;
`endif
                            end else if (m_count > 0) m_count--;
                        end
                    end
                end
                M_PAUSE: if (s) m_state = M_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit l, input logic [7:0] lv, input bit s, input bit p);
        rst = r; load = l; load_val = lv; start = s; pause = p;
        @(posedge clk);
        model_step(r, l, lv, s, p);
        #1;
        check("tens", int'(cnt_tens), m_count / 10);
        check("ones", int'(cnt_ones), m_count % 10);
        check("running", int'(running), (m_state == M_RUN) ? 1 : 0);
        check("done", int'(done), m_done);
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 0, 0);
    endtask

    int lat, pulses, runs;

    initial begin
        // reset dominates load
        cyc(1, 1, 8'h55, 0, 0);
        cyc(1, 1, 8'h55, 0, 0);
        check("reset_all_zero", int'({cnt_tens, cnt_ones, running, done}), 0);

`ifndef BCD_TIMER_AUTO_RELOAD_EN
        // 12 down to 00, done after 12*TICK_DIV cycles
        cyc(0, 1, 8'h12, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        lat = 0; pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            idle();
            if (i == 4) check("first_dec", int'({cnt_tens, cnt_ones}), 8'h11);
            if (done) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        check("done_latency", lat, 48);
        check("done_pulses", pulses, 1);
        cyc(0, 0, 8'h00, 1, 0);
        check("done_start_ignored", int'({cnt_tens, cnt_ones, running}), 0);

        // pause with a partial period of 2, resume finishes the period in 2 cycles
        cyc(0, 1, 8'h05, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) idle();
        cyc(0, 0, 8'h00, 0, 1);
        check("paused_count", int'({cnt_tens, cnt_ones}), 8'h03);
        check("paused_running", int'(running), 0);
        idle(); idle();
        cyc(0, 0, 8'h00, 1, 0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            idle();
            if (lat == 0 && cnt_ones != 4'd3) lat = i;
        end
        check("resume_latency", lat, 2);
`endif

        // clamping and start at zero
        cyc(0, 1, 8'hAB, 0, 0);
        check("clamp_ab", int'({cnt_tens, cnt_ones}), 8'h99);
        cyc(0, 1, 8'h3F, 0, 0);
        check("clamp_3f", int'({cnt_tens, cnt_ones}), 8'h39);
        cyc(0, 1, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        check("start_at_zero", int'(running), 0);

        // load wins over a due tick
        cyc(0, 1, 8'h05, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        idle(); idle(); idle();
        cyc(0, 1, 8'h40, 0, 0);
        check("load_at_tick", int'({cnt_tens, cnt_ones, running, done}), {8'h40, 2'b00});
        cyc(0, 0, 8'h00, 1, 0);
        idle(); idle();
        cyc(1, 0, 8'h00, 0, 0);
        check("rst_mid_run", int'({cnt_tens, cnt_ones, running, done}), 0);

`ifdef BCD_TIMER_AUTO_RELOAD_EN
        // 03 repeats; done every 3*TICK_DIV cycles, running never drops
        cyc(0, 1, 8'h03, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        pulses = 0; runs = 0;
        for (int i = 1; i <= 36; i++) begin
            idle();
            if (done) pulses++;
            if (running) runs++;
        end
        check("reload_pulses", pulses, 36 / (3 * TICK_DIV));
        check("reload_running", runs, 36);
`endif

        // random traffic, biased toward small presets so terminal counts occur
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] lv;
            bit r, l, s, p;
            lv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(1, 4));
            r  = ($urandom_range(0, 127) == 0);
            l  = ($urandom_range(0, 31) == 0);
            s  = ($urandom_range(0, 3) == 0);
            p  = ($urandom_range(0, 15) == 0);
            cyc(r, l, lv, s, p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
